// File: rtl/servo_pwm_capture_if.sv
// Servo PWM capture bus: the raw PWM line in, measurement results out.
// master = capture block, slave = consumer of the measurements.
interface servo_pwm_capture_if #(
    parameter int unsigned CNT_W = 22
);
    logic             pwm_in;
    logic [CNT_W-1:0] high_cnt;
    logic [CNT_W-1:0] period_cnt;
    logic [1:0]       pos_code;
    logic             meas_valid;
    logic             timeout;

    modport master (
        input  pwm_in,
        output high_cnt, period_cnt, pos_code, meas_valid, timeout
    );

    modport slave (
        output pwm_in,
        input  high_cnt, period_cnt, pos_code, meas_valid, timeout
    );
endinterface

// File: rtl/servo_pwm_capture.sv
// Servo PWM receiver: synchronises and glitch-filters the PWM line, measures high time
// and period in clk cycles, and decodes the high time into a 2-bit position code.
module servo_pwm_capture #(
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned FILT_LEN    = 4,
    parameter int unsigned CNT_W       = 22,
    parameter int unsigned TIMEOUT     = 2_500_000,
    parameter int unsigned MIN_HIGH    = 25_000,
    parameter int unsigned T1_MAX      = 112_500,
    parameter int unsigned T2_MAX      = 195_000,
    parameter int unsigned T3_MAX      = 300_000
) (
    input logic                 clk,
    input logic                 rst_n,
    servo_pwm_capture_if.master bus
);
    localparam int unsigned      FILT_W    = $clog2(FILT_LEN + 1);
    localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(TIMEOUT);

    typedef enum logic [1:0] {StIdle, StHigh, StLow} state_e;

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   pwm_s;
    logic [FILT_W-1:0]      filt_cnt_q;
    logic                   pwm_f_q;
    logic                   pwm_d_q;
    logic                   rise;
    logic                   fall;

    state_e           state_q;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_inc;
    logic [CNT_W-1:0] hi_lat_q;
    logic [CNT_W-1:0] high_cnt_q;
    logic [CNT_W-1:0] period_cnt_q;
    logic [1:0]       pos_code_q;
    logic             meas_valid_q;
    logic             timeout_q;

    // Reset to 1 so a line already high at reset does not look like a rise.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '1;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], bus.pwm_in};
        end
    end

    assign pwm_s = sync_q[SYNC_STAGES-1];

    // Level changes only after FILT_LEN consecutive differing samples; both edges
    // see the same delay, so the filtered high time equals the input high time.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            filt_cnt_q <= '0;
            pwm_f_q    <= 1'b1;
            pwm_d_q    <= 1'b1;
        end else begin
            pwm_d_q <= pwm_f_q;
            if (pwm_s == pwm_f_q) begin
                filt_cnt_q <= '0;
            end else if (filt_cnt_q == FILT_W'(FILT_LEN - 1)) begin
                pwm_f_q    <= pwm_s;
                filt_cnt_q <= '0;
            end else begin
                filt_cnt_q <= filt_cnt_q + FILT_W'(1);
            end
        end
    end

    assign rise = pwm_f_q & ~pwm_d_q;
    assign fall = ~pwm_f_q & pwm_d_q;

    always_comb begin
        cnt_inc = cnt_q;
        if (cnt_q != '1) begin
            cnt_inc = cnt_q + CNT_W'(1);
        end
    end

    function automatic logic [1:0] decode(input logic [CNT_W-1:0] h);
        logic [1:0] code;
        code = 2'd0;
        if (h < CNT_W'(MIN_HIGH)) begin
            code = 2'd0;
        end else if (h <= CNT_W'(T1_MAX)) begin
            code = 2'd1;
        end else if (h <= CNT_W'(T2_MAX)) begin
            code = 2'd2;
        end else if (h <= CNT_W'(T3_MAX)) begin
            code = 2'd3;
        end
        return code;
    endfunction

    // Measurement FSM. An edge in the same cycle as cnt == TIMEOUT takes priority.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= StIdle;
            cnt_q        <= '0;
            hi_lat_q     <= '0;
            high_cnt_q   <= '0;
            period_cnt_q <= '0;
            pos_code_q   <= 2'd0;
            meas_valid_q <= 1'b0;
            timeout_q    <= 1'b0;
        end else begin
            meas_valid_q <= 1'b0;
            case (state_q)
                StIdle: begin
                    if (rise) begin
                        state_q <= StHigh;
                        cnt_q   <= CNT_W'(1);
                    end
                end
                StHigh: begin
                    if (fall) begin
                        hi_lat_q <= cnt_q;
                        cnt_q    <= cnt_inc;
                        state_q  <= StLow;
                    end else if (cnt_q == TIMEOUT_C) begin
                        state_q    <= StIdle;
                        timeout_q  <= 1'b1;
                        pos_code_q <= 2'd0;
                    end else begin
                        cnt_q <= cnt_inc;
                    end
                end
                StLow: begin
                    if (rise) begin
                        period_cnt_q <= cnt_q;
                        high_cnt_q   <= hi_lat_q;
                        pos_code_q   <= decode(hi_lat_q);
                        meas_valid_q <= 1'b1;
                        timeout_q    <= 1'b0;
                        cnt_q        <= CNT_W'(1);
                        state_q      <= StHigh;
                    end else if (cnt_q == TIMEOUT_C) begin
                        state_q    <= StIdle;
                        timeout_q  <= 1'b1;
                        pos_code_q <= 2'd0;
                    end else begin
                        cnt_q <= cnt_inc;
                    end
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

    assign bus.high_cnt   = high_cnt_q;
    assign bus.period_cnt = period_cnt_q;
    assign bus.pos_code   = pos_code_q;
    assign bus.meas_valid = meas_valid_q;
    assign bus.timeout    = timeout_q;
endmodule
